hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EXE stage, beside the combinational ALU.
- Owns the architectural HI/LO registers and drives their values into the ALU's HI_IN/LO_IN, so MFHI/MFLO read them there.
- Runs MULT/MULTU/DIV/DIVU iteratively (radix-2 shift-add, restoring division) and performs MTHI/MTLO.
- Busy_OUT stalls the pipeline while an operation is in flight.

---
 rtl/hilo_muldiv_unit_if.sv | 61 ++++++
 rtl/hilo_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_if
//
// Purpose:
//   Request/response bundle between the EXE stage and the HI/LO multiply/divide
//   unit. The pipeline side (master) issues operations and observes HI/LO and
//   the busy/done status; the unit (slave) consumes requests and drives status.
//
// Signals:
//   Start_IN       request valid this cycle
//   ALUControl_IN  operation code (5 DIV, 6 DIVU, 11 MTHI, 12 MTLO, 13 MULT,
//                  14 MULTU; anything else is a no-op)
//   OperandA_IN    rs value: dividend / multiplicand / MTHI-MTLO source
//   OperandB_IN    rt value: divisor / multiplier
//   Flush_IN       abort any in-flight operation, HI/LO untouched
//   HI_OUT         architectural HI register (feeds ALU HI_IN)
//   LO_OUT         architectural LO register (feeds ALU LO_IN)
//   Busy_OUT       operation in flight, pipeline must stall
//   Done_OUT       one-cycle pulse when a mul/div (or divide-by-zero) completes
// -----------------------------------------------------------------------------
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);

    logic             Start_IN;
    logic [5:0]       ALUControl_IN;
    logic [WIDTH-1:0] OperandA_IN;
    logic [WIDTH-1:0] OperandB_IN;
    logic             Flush_IN;
    logic [WIDTH-1:0] HI_OUT;
    logic [WIDTH-1:0] LO_OUT;
    logic             Busy_OUT;
    logic             Done_OUT;

    // Pipeline side: issues requests, reads results and status.
    modport master (
        output Start_IN,
        output ALUControl_IN,
        output OperandA_IN,
        output OperandB_IN,
        output Flush_IN,
        input  HI_OUT,
        input  LO_OUT,
        input  Busy_OUT,
        input  Done_OUT
    );

    // Unit side: consumes requests, owns HI/LO and status.
    modport slave (
        input  Start_IN,
        input  ALUControl_IN,
        input  OperandA_IN,
        input  OperandB_IN,
        input  Flush_IN,
        output HI_OUT,
        output LO_OUT,
        output Busy_OUT,
        output Done_OUT
    );

endinterface

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Purpose:
//   Iterative multiply/divide unit sitting beside the EXE-stage ALU. It owns the
//   architectural HI/LO registers, performs MTHI/MTLO in a single edge, and runs
//   MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring division) over ITER
//   iterations followed by one sign-fixup cycle.
//
//   Signed operations work on magnitudes; the result signs are remembered at
//   issue and applied in the FIX state. |0x80000000| is 0x80000000, which is
//   representable as an unsigned WIDTH-bit magnitude, so no extra bit is needed
//   to hold operands.
//
// Ports:
//   CLOCK   rising-edge clock
//   RESET   asynchronous active-low reset (clears HI/LO, aborts any operation)
//   bus     hilo_muldiv_unit_if.slave: request inputs, HI/LO and busy/done
//
// Parameters:
//   WIDTH   operand and HI/LO width (only 32 is exercised)
//   ITER    iterations per mul/div; must equal WIDTH
// -----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    hilo_muldiv_unit_if.slave    bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int              CW       = $clog2(ITER);
    localparam logic [CW-1:0]   LAST_IT  = CW'(ITER - 1);

    localparam logic [5:0] OP_DIV   = 6'd5;
    localparam logic [5:0] OP_DIVU  = 6'd6;
    localparam logic [5:0] OP_MTHI  = 6'd11;
    localparam logic [5:0] OP_MTLO  = 6'd12;
    localparam logic [5:0] OP_MULT  = 6'd13;
    localparam logic [5:0] OP_MULTU = 6'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Shared datapath: r_upper/r_lower form the product register for multiply
    // and the partial-remainder/quotient pair for divide.
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient sign (signA ^ signB)
    logic               r_neg_rem;   // remainder sign (signA)

    // Control strobes from the FSM
    logic               w_load;
    logic               w_step;
    logic               w_fix;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_done_next;

    // Operand decode
    logic               w_op_div;
    logic               w_op_mul;
    logic               w_op_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;

    // Iteration datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;

    // Sign fixup
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // -------------------------------------------------------------------------
    // Operand decode and magnitudes
    // -------------------------------------------------------------------------
    assign w_op_div    = (bus.ALUControl_IN == OP_DIV)  || (bus.ALUControl_IN == OP_DIVU);
    assign w_op_mul    = (bus.ALUControl_IN == OP_MULT) || (bus.ALUControl_IN == OP_MULTU);
    assign w_op_signed = (bus.ALUControl_IN == OP_DIV)  || (bus.ALUControl_IN == OP_MULT);

    assign w_a_neg  = w_op_signed & bus.OperandA_IN[WIDTH-1];
    assign w_b_neg  = w_op_signed & bus.OperandB_IN[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (-bus.OperandA_IN) : bus.OperandA_IN;
    assign w_b_mag  = w_b_neg ? (-bus.OperandB_IN) : bus.OperandB_IN;
    assign w_b_zero = (bus.OperandB_IN == '0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: state and all architectural registers use non-blocking assignments
    // so every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control strobes
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        w_done_next  = 1'b0;

        if (bus.Flush_IN) begin
            // Abort wins over everything, including a Start in the same cycle.
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start_IN) begin
                        if (bus.ALUControl_IN == OP_MTHI) begin
                            w_wr_hi = 1'b1;
                        end else if (bus.ALUControl_IN == OP_MTLO) begin
                            w_wr_lo = 1'b1;
                        end else if (w_op_div && w_b_zero) begin
                            // Divide by zero completes immediately, HI/LO kept.
                            w_done_next = 1'b1;
                        end else if (w_op_div || w_op_mul) begin
                            w_load       = 1'b1;
                            w_next_state = S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    w_step = 1'b1;
                    if (r_count == LAST_IT) begin
                        w_next_state = S_FIX;
                    end
                end

                S_FIX: begin
                    w_fix        = 1'b1;
                    w_done_next  = 1'b1;
                    w_next_state = S_IDLE;
                end

                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Iteration counter
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Iteration datapath (combinational part)
    // -------------------------------------------------------------------------
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole product register right.
    assign w_mul_sum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The shifted remainder is below 2*divisor, so bit WIDTH of the difference
    // is set exactly when the subtraction would go negative.
    assign w_div_shift = {r_upper, r_lower[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_diff[WIDTH];

    // -------------------------------------------------------------------------
    // Iteration datapath (registers)
    // -------------------------------------------------------------------------
    // NOTE: the working registers carry no reset; they are always loaded at
    // issue before being read, and HI/LO only accept them in the FIX state.
    always_ff @(posedge CLOCK) begin
        if (w_load) begin
            r_upper   <= '0;
            r_opnd    <= w_op_div ? w_b_mag : w_a_mag;
            r_lower   <= w_op_div ? w_a_mag : w_b_mag;
            r_is_div  <= w_op_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
        end else if (w_step) begin
            if (r_is_div) begin
                // Restoring step: keep the difference only when it fits;
                // quotient bits enter at the LSB as dividend bits leave the MSB.
                r_upper <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                r_lower <= {r_lower[WIDTH-2:0], w_div_ok};
            end else begin
                r_upper <= w_mul_sum[WIDTH:1];
                r_lower <= {w_mul_sum[0], r_lower[WIDTH-1:1]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sign fixup
    // -------------------------------------------------------------------------
    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = r_neg_res ? (-w_prod)  : w_prod;
    assign w_quo_fix  = r_neg_res ? (-r_lower) : r_lower;
    assign w_rem_fix  = r_neg_rem ? (-r_upper) : r_upper;

    // -------------------------------------------------------------------------
    // Architectural HI/LO and done pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_wr_hi) begin
                r_hi <= bus.OperandA_IN;
            end
            if (w_wr_lo) begin
                r_lo <= bus.OperandA_IN;
            end
            if (w_fix) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.HI_OUT   = r_hi;
    assign bus.LO_OUT   = r_lo;
    assign bus.Busy_OUT = (r_state != S_IDLE);
    assign bus.Done_OUT = r_done;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_unit
//
// Directed bench for hilo_muldiv_unit. Stimulus pushes the expected HI/LO and
// completion cycle of each mul/div into a scoreboard; a monitor pops and
// compares whenever Done_OUT is seen. Non-completing behaviour (MTHI/MTLO,
// flush, reset) is checked directly with check().
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] OP_DIV   = 6'd5;
    localparam logic [5:0] OP_DIVU  = 6'd6;
    localparam logic [5:0] OP_MTHI  = 6'd11;
    localparam logic [5:0] OP_MTLO  = 6'd12;
    localparam logic [5:0] OP_MULT  = 6'd13;
    localparam logic [5:0] OP_MULTU = 6'd14;

    // Edges from the issuing edge to the one that writes HI/LO.
    localparam int LAT_MD = 33;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(
        .WIDTH (W),
        .ITER  (W)
    ) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request for exactly one edge; returns 1 ns after that edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start_IN      = 1'b1;
        bus.ALUControl_IN = op;
        bus.OperandA_IN   = a;
        bus.OperandB_IN   = b;
        @(posedge clk);
        #1;
        bus.Start_IN      = 1'b0;
    endtask

    // Call right after issue(): cyc already reflects the issuing edge.
    task automatic expect_done(input string name, input logic [31:0] hi,
                               input logic [31:0] lo, input int lat);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        e.cyc  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.Busy_OUT && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_complete"}, 64'(ok), 64'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.Done_OUT === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got Done_OUT=1, expected no completion (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"},   bus.HI_OUT,   mon_e.hi);
                check({mon_e.name, "_lo"},   bus.LO_OUT,   mon_e.lo);
                check({mon_e.name, "_cyc"},  64'(cyc),     64'(mon_e.cyc));
                check({mon_e.name, "_busy"}, bus.Busy_OUT, 64'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Start_IN      = 1'b0;
        bus.ALUControl_IN = '0;
        bus.OperandA_IN   = '0;
        bus.OperandB_IN   = '0;
        bus.Flush_IN      = 1'b0;

        // Reset state
        #12;
        check("rst_hi",   bus.HI_OUT,   64'd0);
        check("rst_lo",   bus.LO_OUT,   64'd0);
        check("rst_busy", bus.Busy_OUT, 64'd0);
        check("rst_done", bus.Done_OUT, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MTHI then MTLO on consecutive edges
        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi",   bus.HI_OUT,   64'hDEADBEEF);
        check("mthi_busy", bus.Busy_OUT, 64'd0);
        issue(OP_MTLO, 32'h00001234, 32'h0);
        check("mtlo_lo", bus.LO_OUT, 64'h1234);
        check("mtlo_hi", bus.HI_OUT, 64'hDEADBEEF);

        // Multiply / divide vectors (hand-computed)
        issue(OP_MULT, 32'hFFFFFFFF, 32'h2);
        expect_done("mult_m1x2", 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MD);
        check("mult_busy", bus.Busy_OUT, 64'd1);
        wait_idle("mult_m1x2");

        issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
        expect_done("multu_ffx2", 32'h00000001, 32'hFFFFFFFE, LAT_MD);
        wait_idle("multu_ffx2");

        issue(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB);
        expect_done("mult_m3xm5", 32'h00000000, 32'h0000000F, LAT_MD);
        wait_idle("mult_m3xm5");

        issue(OP_MULT, 32'h80000000, 32'h80000000);
        expect_done("mult_min2", 32'h40000000, 32'h00000000, LAT_MD);
        wait_idle("mult_min2");

        issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
        expect_done("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD, LAT_MD);
        wait_idle("div_m7d2");

        issue(OP_DIV, 32'h7, 32'hFFFFFFFE);
        expect_done("div_7dm2", 32'h00000001, 32'hFFFFFFFD, LAT_MD);
        wait_idle("div_7dm2");

        issue(OP_DIVU, 32'h7, 32'h2);
        expect_done("divu_7d2", 32'h00000001, 32'h00000003, LAT_MD);
        wait_idle("divu_7d2");

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        expect_done("div_min_m1", 32'h00000000, 32'h80000000, LAT_MD);
        wait_idle("div_min_m1");

        // Divide by zero: Done next cycle, never busy, HI/LO unchanged
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        issue(OP_DIVU, 32'h7, 32'h0);
        expect_done("divu_by0", 32'h11, 32'h22, 0);
        check("div0_busy", bus.Busy_OUT, 64'd0);
        @(negedge clk);
        check("div0_busy_later", bus.Busy_OUT, 64'd0);
        wait_idle("divu_by0");

        // Flush at CALC iteration 10: busy drops, no Done, HI/LO kept
        issue(OP_MULT, 32'h3, 32'h5);
        repeat (9) @(posedge clk);
        #1;
        bus.Flush_IN = 1'b1;
        @(posedge clk);
        #1;
        bus.Flush_IN = 1'b0;
        check("flush_busy", bus.Busy_OUT, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", bus.HI_OUT, 64'h11);
        check("flush_lo", bus.LO_OUT, 64'h22);

        // Start in the same cycle as Flush is ignored
        bus.Flush_IN = 1'b1;
        issue(OP_MTHI, 32'hCAFEF00D, 32'h0);
        check("flush_start_hi", bus.HI_OUT, 64'h11);
        issue(OP_MULT, 32'h3, 32'h5);
        bus.Flush_IN = 1'b0;
        check("flush_start_busy", bus.Busy_OUT, 64'd0);

        // MTLO while busy is ignored
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        expect_done("divu_100d7", 32'h2, 32'hE, LAT_MD);
        repeat (3) @(posedge clk);
        #1;
        issue(OP_MTLO, 32'h00000BAD, 32'h0);
        check("busy_mtlo_lo", bus.LO_OUT, 64'h22);
        wait_idle("divu_100d7");

        // Reset mid-CALC with HI/LO loaded: cleared at once, no Done later
        issue(OP_MULT, 32'h3, 32'h5);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_hi",   bus.HI_OUT,   64'd0);
        check("rst_mid_lo",   bus.LO_OUT,   64'd0);
        check("rst_mid_busy", bus.Busy_OUT, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_mid_after_busy", bus.Busy_OUT, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
